// File: rtl/packet_store_fwd_buffer.sv
// packet_store_fwd_buffer: store-and-forward frame buffer; commits good frames, rewinds bad ones,
// and streams committed frames out word by word with a last-word flag and per-frame length.
module packet_store_fwd_buffer #(
  parameter int pDATA_WIDTH = 8,
  parameter int pDEPTH_RAM = 4096,
  parameter int pLEN_DEPTH = 64,
  parameter int pMIN_PACKET_LENGTH = 64,
  parameter int pMAX_PACKET_LENGTH = 1536,
  parameter int pCNT_WIDTH = 16
) (
  input  logic iclk,
  input  logic i_rst,
  input  logic idv,
  input  logic [pDATA_WIDTH-1:0] irx_d,
  input  logic irx_er,
  input  logic icrc_ok,
  input  logic ird_en,
  output logic [pDATA_WIDTH-1:0] or_data,
  output logic odv,
  output logic olast,
  output logic [$clog2(pMAX_PACKET_LENGTH+1)-1:0] olen_pac,
  output logic oempty,
  output logic ofull,
  output logic [pCNT_WIDTH-1:0] ocnt_ok,
  output logic [pCNT_WIDTH-1:0] ocnt_drop
);
  localparam int AW = pDEPTH_RAM > 1 ? $clog2(pDEPTH_RAM) : 1;
  localparam int CW = $clog2(pDEPTH_RAM + 1);
  localparam int LW = $clog2(pMAX_PACKET_LENGTH + 1);
  localparam int FAW = pLEN_DEPTH > 1 ? $clog2(pLEN_DEPTH) : 1;
  localparam int FCW = $clog2(pLEN_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(pDEPTH_RAM);
  localparam logic [CW-1:0] MIN_C = CW'(pMIN_PACKET_LENGTH);
  localparam logic [CW-1:0] MAX_C = CW'(pMAX_PACKET_LENGTH);
  localparam logic [FCW-1:0] LEN_C = FCW'(pLEN_DEPTH);
  typedef enum logic [1:0] {IDLE, WRITE, STATUS, DISCARD} state_t;
  state_t st, st_n;
  logic [pDATA_WIDTH-1:0] ram [pDEPTH_RAM];
  logic [LW-1:0] len_mem [pLEN_DEPTH];
  logic [AW-1:0] wr_succ, wr_now, rd_ptr;
  logic [FAW-1:0] lw_ptr, lr_ptr;
  logic [FCW-1:0] lcnt, lcnt_n;
  logic [CW-1:0] cnt, cnt_n, cu, cu_n, free, free_n;
  logic [LW-1:0] rd_cnt, head_len;
  logic err, err_n, pop, last_pop, wr_en, commit, drop, room;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(pDEPTH_RAM - 1) ? '0 : p + AW'(1);
  endfunction
  function automatic logic [FAW-1:0] linc(input logic [FAW-1:0] p);
    return p == FAW'(pLEN_DEPTH - 1) ? '0 : p + FAW'(1);
  endfunction
  assign head_len = len_mem[lr_ptr];
  assign olen_pac = oempty ? '0 : head_len;
  // cu counts committed-unread words, cnt the words of the frame being written
  always_comb begin
    pop = ird_en && !oempty;
    last_pop = pop && (rd_cnt + LW'(1) == head_len);
    free = DEPTH_C - (cu - CW'(pop)) - cnt;
    room = free > CW'(1);
    st_n = st;
    cnt_n = cnt;
    err_n = err;
    wr_en = 1'b0;
    commit = 1'b0;
    drop = 1'b0;
    case (st)
      IDLE: if (idv) begin
        drop = lcnt == LEN_C || !room;
        st_n = drop ? DISCARD : WRITE;
        wr_en = !drop;
        cnt_n = CW'(!drop);
        err_n = irx_er;
      end
      WRITE: if (!idv) st_n = STATUS;
        else if (!room || cnt == MAX_C) begin
          st_n = DISCARD;
          drop = 1'b1;
          cnt_n = '0;
        end else begin
          wr_en = 1'b1;
          cnt_n = cnt + CW'(1);
          err_n = err | irx_er;
        end
      STATUS: begin
        st_n = IDLE;
        commit = icrc_ok && !err && cnt >= MIN_C && cnt <= MAX_C;
        drop = !commit;
        cnt_n = '0;
      end
      DISCARD: st_n = idv ? DISCARD : IDLE;
    endcase
    cu_n = cu - CW'(pop) + (commit ? cnt : '0);
    free_n = DEPTH_C - cu_n - cnt_n;
    lcnt_n = lcnt + FCW'(commit) - FCW'(last_pop);
  end
  always_ff @(posedge iclk) begin
    if (i_rst) begin
      st <= IDLE;
      cnt <= '0;
      err <= 1'b0;
      cu <= '0;
      wr_now <= '0;
      wr_succ <= '0;
      rd_ptr <= '0;
      rd_cnt <= '0;
      lw_ptr <= '0;
      lr_ptr <= '0;
      lcnt <= '0;
      or_data <= '0;
      odv <= 1'b0;
      olast <= 1'b0;
      oempty <= 1'b1;
      ofull <= 1'b0;
      ocnt_ok <= '0;
      ocnt_drop <= '0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      err <= err_n;
      cu <= cu_n;
      wr_now <= drop ? wr_succ : wr_en ? inc(wr_now) : wr_now;
      wr_succ <= commit ? wr_now : wr_succ;
      rd_ptr <= pop ? inc(rd_ptr) : rd_ptr;
      rd_cnt <= last_pop ? '0 : pop ? rd_cnt + LW'(1) : rd_cnt;
      lw_ptr <= commit ? linc(lw_ptr) : lw_ptr;
      lr_ptr <= last_pop ? linc(lr_ptr) : lr_ptr;
      lcnt <= lcnt_n;
      or_data <= pop ? ram[rd_ptr] : or_data;
      odv <= pop;
      olast <= last_pop;
      oempty <= lcnt_n == '0;
      ofull <= free_n < MAX_C || lcnt_n == LEN_C;
      if (commit && !(&ocnt_ok)) ocnt_ok <= ocnt_ok + pCNT_WIDTH'(1);
      if (drop && !(&ocnt_drop)) ocnt_drop <= ocnt_drop + pCNT_WIDTH'(1);
    end
  end
  always_ff @(posedge iclk) begin
    if (wr_en) ram[wr_now] <= irx_d;
    if (commit) len_mem[lw_ptr] <= LW'(cnt);
  end
endmodule

// File: tb/tb_packet_store_fwd_buffer.sv
// tb_packet_store_fwd_buffer: a default-sized buffer and a 200-word buffer, each checked every cycle
// against a frame-queue model, plus directed literal checks from the hand-computed scenarios.
module tb_packet_store_fwd_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] idv = '0, er = '0, crc = '0, rd = '0;
  logic [1:0][7:0] rxd = '0;
  logic [1:0][7:0] o_data;
  logic [1:0] o_dv, o_last, o_empty, o_full;
  logic [1:0][10:0] o_len;
  logic [1:0][15:0] o_ok, o_drop;
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input int d, input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (inst %0d) at %0t: got %0d, expected %0d", nm, d, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int DEPTH = g == 0 ? 4096 : 200;
    localparam int MAXL = g == 0 ? 1536 : 150;
    localparam int LEN_D = g == 0 ? 64 : 4;
    localparam int MINL = 64;
    localparam int LW = $clog2(MAXL + 1);
    logic [LW-1:0] olen;
    packet_store_fwd_buffer #(
      .pDATA_WIDTH(8), .pDEPTH_RAM(DEPTH), .pLEN_DEPTH(LEN_D),
      .pMIN_PACKET_LENGTH(MINL), .pMAX_PACKET_LENGTH(MAXL), .pCNT_WIDTH(16)
    ) dut (
      .iclk(clk), .i_rst(rst), .idv(idv[g]), .irx_d(rxd[g]), .irx_er(er[g]),
      .icrc_ok(crc[g]), .ird_en(rd[g]), .or_data(o_data[g]), .odv(o_dv[g]),
      .olast(o_last[g]), .olen_pac(olen), .oempty(o_empty[g]), .ofull(o_full[g]),
      .ocnt_ok(o_ok[g]), .ocnt_drop(o_drop[g])
    );
    assign o_len[g] = 11'(olen);
    // Model: committed words and frame lengths as queues; phase 0 idle, 1 receiving, 2 status, 3 discarding
    int q_data[$], q_len[$], cur[$];
    int rd_off, phase, free, e_data, e_len, e_ok, e_drop;
    bit cur_err, len_full, e_dv, e_last, e_empty, e_full, armed;
    always @(posedge clk) begin
      if (rst) begin
        q_data.delete(); q_len.delete(); cur.delete();
        rd_off = 0; phase = 0; cur_err = 0;
        e_data = 0; e_dv = 0; e_last = 0; e_len = 0; e_empty = 1; e_full = 0;
        e_ok = 0; e_drop = 0; armed = 1;
      end else begin
        len_full = q_len.size() == LEN_D;
        e_dv = rd[g] && q_len.size() > 0;
        e_last = 0;
        if (e_dv) begin
          e_data = q_data.pop_front();
          rd_off++;
          if (rd_off == q_len[0]) begin
            e_last = 1;
            void'(q_len.pop_front());
            rd_off = 0;
          end
        end
        free = DEPTH - q_data.size() - cur.size();
        if (phase == 0) begin
          if (idv[g]) begin
            if (len_full || free <= 1) begin phase = 3; if (e_drop < 65535) e_drop++; end
            else begin cur.push_back(rxd[g]); cur_err = er[g]; phase = 1; end
          end
        end else if (phase == 1) begin
          if (!idv[g]) phase = 2;
          else if (cur.size() == MAXL || free <= 1) begin
            phase = 3; cur.delete(); if (e_drop < 65535) e_drop++;
          end else begin cur.push_back(rxd[g]); cur_err |= er[g]; end
        end else if (phase == 2) begin
          phase = 0;
          if (crc[g] && !cur_err && cur.size() >= MINL && cur.size() <= MAXL) begin
            q_data = {q_data, cur};
            q_len.push_back(cur.size());
            if (e_ok < 65535) e_ok++;
          end else if (e_drop < 65535) e_drop++;
          cur.delete();
        end else if (!idv[g]) phase = 0;
        e_empty = q_len.size() == 0;
        e_len = e_empty ? 0 : q_len[0];
        e_full = (DEPTH - q_data.size() - cur.size() < MAXL) || q_len.size() == LEN_D;
      end
    end
    always @(negedge clk) if (armed) begin
      chk(g, "or_data", o_data[g], e_data);
      chk(g, "odv", o_dv[g], e_dv);
      chk(g, "olast", o_last[g], e_last);
      chk(g, "olen_pac", o_len[g], e_len);
      chk(g, "oempty", o_empty[g], e_empty);
      chk(g, "ofull", o_full[g], e_full);
      chk(g, "ocnt_ok", o_ok[g], e_ok);
      chk(g, "ocnt_drop", o_drop[g], e_drop);
    end
  end

  task automatic send_frame(input int d, input int n, input int base, input bit good, input int er_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idv[d] = 1'b1;
      rxd[d] = 8'(base + i);
      er[d] = i == er_at;
    end
    @(negedge clk);
    idv[d] = 1'b0;
    er[d] = 1'b0;
    crc[d] = good;
    @(negedge clk);
    @(negedge clk);
    crc[d] = 1'b0;
  endtask

  task automatic read_frames(input int d, input int n, input int flen, input int base);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk(d, "rd_data", o_data[d], (base + i - 1) & 255);
        chk(d, "rd_last", o_last[d], (i % flen) == 0);
      end
      rd[d] = i < n;
    end
  endtask

  task automatic wait_ready(input int d);
    for (int t = 0; t < 1000 && o_empty[d]; t++) @(negedge clk);
    chk(d, "ready_wait", o_empty[d], 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk(0, "reset_empty", o_empty[0], 1);
    chk(0, "reset_full", o_full[0], 0);
    chk(1, "reset_ok", o_ok[1], 0);
    // single good 64-word frame
    send_frame(0, 64, 0, 1, -1);
    chk(0, "c64_empty", o_empty[0], 0);
    chk(0, "c64_len", o_len[0], 64);
    chk(0, "c64_ok", o_ok[0], 1);
    read_frames(0, 64, 64, 0);
    // errored frame then good frame
    send_frame(0, 100, 0, 1, 10);
    send_frame(0, 80, 100, 1, -1);
    chk(0, "err_drop", o_drop[0], 1);
    chk(0, "err_len", o_len[0], 80);
    chk(0, "err_ok", o_ok[0], 2);
    read_frames(0, 80, 80, 100);
    // length boundaries
    send_frame(0, 63, 0, 1, -1);
    send_frame(0, 1537, 0, 1, -1);
    chk(0, "bnd_drop", o_drop[0], 3);
    chk(0, "bnd_empty", o_empty[0], 1);
    send_frame(0, 1536, 0, 1, -1);
    chk(0, "max_len", o_len[0], 1536);
    chk(0, "max_ok", o_ok[0], 3);
    read_frames(0, 1536, 1536, 0);
    // small RAM: concurrent write/read across the wrap point
    fork
      for (int k = 0; k < 6; k++) send_frame(1, 70, k * 70, 1, -1);
      for (int k = 0; k < 6; k++) begin
        wait_ready(1);
        read_frames(1, 70, 70, k * 70);
      end
    join
    chk(1, "wrap_ok", o_ok[1], 6);
    chk(1, "wrap_drop", o_drop[1], 0);
    // two queued frames read with ird_en held across the boundary
    send_frame(1, 70, 0, 1, -1);
    send_frame(1, 70, 70, 1, -1);
    chk(1, "b2b_len", o_len[1], 70);
    read_frames(1, 140, 70, 0);
    chk(1, "b2b_empty", o_empty[1], 1);
    // overflow drop, then space recovered by reading
    send_frame(1, 100, 0, 1, -1);
    chk(1, "ovf_full", o_full[1], 1);
    send_frame(1, 120, 0, 1, -1);
    chk(1, "ovf_drop", o_drop[1], 1);
    chk(1, "ovf_len", o_len[1], 100);
    chk(1, "ovf_ok", o_ok[1], 9);
    read_frames(1, 100, 100, 0);
    send_frame(1, 120, 50, 1, -1);
    chk(1, "rec_ok", o_ok[1], 10);
    chk(1, "rec_len", o_len[1], 120);
    read_frames(1, 120, 120, 50);
    // reset in the middle of a write and a read
    send_frame(0, 64, 0, 1, -1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rd[0] = 1'b1;
      idv[0] = 1'b1;
      rxd[0] = 8'(200 + i);
    end
    @(negedge clk);
    chk(0, "pre_rst_dv", o_dv[0], 1);
    rst = 1'b1;
    idv[0] = 1'b0;
    rd[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk(0, "rst_data", o_data[0], 0);
    chk(0, "rst_dv", o_dv[0], 0);
    chk(0, "rst_last", o_last[0], 0);
    chk(0, "rst_len", o_len[0], 0);
    chk(0, "rst_empty", o_empty[0], 1);
    chk(0, "rst_full", o_full[0], 0);
    chk(0, "rst_ok", o_ok[0], 0);
    chk(0, "rst_drop", o_drop[0], 0);
    send_frame(0, 64, 7, 1, -1);
    chk(0, "post_ok", o_ok[0], 1);
    chk(0, "post_len", o_len[0], 64);
    read_frames(0, 64, 64, 7);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
